// File: rtl/datapath_seq.sv
// Self-sequencing datapath: register file, A/B operand registers, shifter, ALU,
// C result register and {N,V,Z} status, driven by an internal command FSM.
module datapath_seq #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PCW   = 8,
  localparam int RA   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [3:0]       cmd_vsel,
  input  logic [RA-1:0]    cmd_rn,
  input  logic [RA-1:0]    cmd_rm,
  input  logic [RA-1:0]    cmd_rd,
  input  logic [1:0]       cmd_aluop,
  input  logic [1:0]       cmd_shift,
  input  logic             cmd_asel,
  input  logic             cmd_bsel,
  input  logic             cmd_wb,
  input  logic [WIDTH-1:0] sximm8,
  input  logic [WIDTH-1:0] sximm5,
  input  logic [WIDTH-1:0] mdata,
  input  logic [PCW-1:0]   PC,
  output logic [WIDTH-1:0] datapath_out,
  output logic [2:0]       status,
  input  logic [RA-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RDA  = 3'd1;
  localparam logic [2:0] S_RDB  = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  logic [2:0]       state;
  logic [3:0]       vsel_q;
  logic [RA-1:0]    rn_q;
  logic [RA-1:0]    rm_q;
  logic [RA-1:0]    rd_q;
  logic [1:0]       aluop_q;
  logic [1:0]       shift_q;
  logic             asel_q;
  logic             bsel_q;
  logic             wb_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [2:0]       status_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] regs [NREGS];

  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic [WIDTH-1:0] wb_src;
  logic [WIDTH-1:0] pc_ext;
  logic             vsel_legal;
  logic             write_en;

  assign pc_ext       = WIDTH'(PC);
  assign vsel_legal   = (vsel_q == 4'b1000) || (vsel_q == 4'b0100) ||
                        (vsel_q == 4'b0010) || (vsel_q == 4'b0001);
  assign write_en     = (state == S_WB) && wb_q && vsel_legal;
  assign busy         = (state != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign datapath_out = c_q;
  assign status       = status_q;
  assign dbg_data     = regs[dbg_addr];

  // Shifter acts on B before the immediate mux; sximm5 is sampled live in EXEC.
  always_comb begin
    b_shift = b_q;
    case (shift_q)
      2'b01:   b_shift = {b_q[WIDTH-2:0], 1'b0};
      2'b10:   b_shift = {1'b0, b_q[WIDTH-1:1]};
      2'b11:   b_shift = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: b_shift = b_q;
    endcase
    a_in  = asel_q ? '0 : a_q;
    b_in  = bsel_q ? sximm5 : b_shift;
    alu_v = 1'b0;
    case (aluop_q)
      2'b00: begin
        alu_res = a_in + b_in;
        alu_v   = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (alu_res[WIDTH-1] != a_in[WIDTH-1]);
      end
      2'b01: begin
        alu_res = a_in - b_in;
        alu_v   = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (alu_res[WIDTH-1] != a_in[WIDTH-1]);
      end
      2'b10:   alu_res = a_in & b_in;
      default: alu_res = ~b_in;
    endcase
  end

  always_comb begin
    case (vsel_q)
      4'b1000: wb_src = mdata;
      4'b0100: wb_src = sximm8;
      4'b0010: wb_src = pc_ext;
      default: wb_src = c_q;
    endcase
  end

  // ALU commands walk RDA/RDB/EXEC; direct and illegal commands go straight to WB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      vsel_q   <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      aluop_q  <= '0;
      shift_q  <= '0;
      asel_q   <= 1'b0;
      bsel_q   <= 1'b0;
      wb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            vsel_q  <= cmd_vsel;
            rn_q    <= cmd_rn;
            rm_q    <= cmd_rm;
            rd_q    <= cmd_rd;
            aluop_q <= cmd_aluop;
            shift_q <= cmd_shift;
            asel_q  <= cmd_asel;
            bsel_q  <= cmd_bsel;
            wb_q    <= cmd_wb;
            state   <= (cmd_vsel == 4'b0001) ? S_RDA : S_WB;
          end
        end
        S_RDA: begin
          a_q   <= regs[rn_q];
          state <= S_RDB;
        end
        S_RDB: begin
          b_q   <= regs[rm_q];
          state <= S_EXEC;
        end
        S_EXEC: begin
          c_q      <= alu_res;
          status_q <= {alu_res[WIDTH-1], alu_v, (alu_res == '0)};
          state    <= S_WB;
        end
        S_WB: begin
          if (write_en) regs[rd_q] <= wb_src;
          done_q <= 1'b1;
          err_q  <= !vsel_legal;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: directed checks on a 16-bit/8-register instance and a
// randomized run of an 8-bit/4-register instance against an arithmetic model.
module tb_datapath_seq;

  logic clk = 1'b0;
  logic reset_n;
  always #10 clk = ~clk;

  // 16-bit, 8-register instance
  logic        s_start, s_busy, s_done, s_err, s_asel, s_bsel, s_wb;
  logic [3:0]  s_vsel;
  logic [2:0]  s_rn, s_rm, s_rd, s_dbg_addr, s_status;
  logic [1:0]  s_aluop, s_shift;
  logic [15:0] s_imm8, s_imm5, s_mdata, s_out, s_dbg_data;
  logic [7:0]  s_pc;

  // 8-bit, 4-register instance
  logic        e_start, e_busy, e_done, e_err, e_asel, e_bsel, e_wb;
  logic [3:0]  e_vsel;
  logic [1:0]  e_rn, e_rm, e_rd, e_dbg_addr, e_aluop, e_shift;
  logic [2:0]  e_status;
  logic [7:0]  e_imm8, e_imm5, e_mdata, e_out, e_dbg_data, e_pc;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mrf [4];
  logic [7:0] mc;
  logic [2:0] mstat;

  datapath_seq #(.WIDTH(16), .NREGS(8), .PCW(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(s_start), .busy(s_busy), .done(s_done), .err(s_err),
    .cmd_vsel(s_vsel), .cmd_rn(s_rn), .cmd_rm(s_rm), .cmd_rd(s_rd), .cmd_aluop(s_aluop),
    .cmd_shift(s_shift), .cmd_asel(s_asel), .cmd_bsel(s_bsel), .cmd_wb(s_wb),
    .sximm8(s_imm8), .sximm5(s_imm5), .mdata(s_mdata), .PC(s_pc),
    .datapath_out(s_out), .status(s_status), .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data)
  );

  datapath_seq #(.WIDTH(8), .NREGS(4), .PCW(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(e_start), .busy(e_busy), .done(e_done), .err(e_err),
    .cmd_vsel(e_vsel), .cmd_rn(e_rn), .cmd_rm(e_rm), .cmd_rd(e_rd), .cmd_aluop(e_aluop),
    .cmd_shift(e_shift), .cmd_asel(e_asel), .cmd_bsel(e_bsel), .cmd_wb(e_wb),
    .sximm8(e_imm8), .sximm5(e_imm5), .mdata(e_mdata), .PC(e_pc),
    .datapath_out(e_out), .status(e_status), .dbg_addr(e_dbg_addr), .dbg_data(e_dbg_data)
  );

  // Called at a negedge; returns at the negedge of the done cycle (cyc=0 if none).
  task automatic issue16(input logic [3:0] vsel, input logic [2:0] rn, input logic [2:0] rm,
                         input logic [2:0] rd, input logic [1:0] aluop, input logic [1:0] shift,
                         input logic asel, input logic bsel, input logic wb, output int cyc);
    s_vsel = vsel; s_rn = rn; s_rm = rm; s_rd = rd; s_aluop = aluop; s_shift = shift;
    s_asel = asel; s_bsel = bsel; s_wb = wb; s_start = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (s_done) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    s_start = 0; s_vsel = 0; s_rn = 0; s_rm = 0; s_rd = 0; s_aluop = 0; s_shift = 0;
    s_asel = 0; s_bsel = 0; s_wb = 0; s_imm8 = 0; s_imm5 = 0; s_mdata = 0; s_pc = 0; s_dbg_addr = 0;
    e_start = 0; e_vsel = 0; e_rn = 0; e_rm = 0; e_rd = 0; e_aluop = 0; e_shift = 0;
    e_asel = 0; e_bsel = 0; e_wb = 0; e_imm8 = 0; e_imm5 = 0; e_mdata = 0; e_pc = 0; e_dbg_addr = 0;
    repeat (2) @(negedge clk);
    n_vec++; if (s_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy got %b want 0", s_busy); end
    n_vec++; if (s_done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done got %b want 0", s_done); end
    n_vec++; if (s_status !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_status got %b want 000", s_status); end
    n_vec++; if (s_out !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset_out got %h want 0000", s_out); end
    n_vec++; if (e_out !== 8'h00 || e_status !== 3'b000) begin
      n_bad++; $display("[TB] FAIL reset8 got out=%h st=%b want 00/000", e_out, e_status);
    end
    for (int i = 0; i < 8; i++) begin
      s_dbg_addr = 3'(i); #1;
      n_vec++; if (s_dbg_data !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset_reg%0d got %h want 0000", i, s_dbg_data); end
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
    mc = 8'h00; mstat = 3'b000;
  endtask

  task automatic test_direct;
    int cyc;
    s_imm8 = 16'h0007;
    issue16(4'b0100, 3'd0, 3'd0, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, cyc);
    n_vec++; if (cyc != 2) begin n_bad++; $display("[TB] FAIL direct_latency got %0d want 2", cyc); end
    n_vec++; if (s_err !== 1'b0) begin n_bad++; $display("[TB] FAIL direct_err got %b want 0", s_err); end
    s_dbg_addr = 3'd1; #1;
    n_vec++; if (s_dbg_data !== 16'h0007) begin n_bad++; $display("[TB] FAIL direct_r1 got %h want 0007", s_dbg_data); end
    s_pc = 8'hA5;
    issue16(4'b0010, 3'd0, 3'd0, 3'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, cyc);
    n_vec++; if (cyc != 2) begin n_bad++; $display("[TB] FAIL pc_latency got %0d want 2", cyc); end
    s_dbg_addr = 3'd2; #1;
    n_vec++; if (s_dbg_data !== 16'h00A5) begin n_bad++; $display("[TB] FAIL pc_r2 got %h want 00A5", s_dbg_data); end
    n_vec++; if (s_out !== 16'h0000 || s_status !== 3'b000) begin
      n_bad++; $display("[TB] FAIL direct_c_kept got %h/%b want 0000/000", s_out, s_status);
    end
    s_mdata = 16'h0003;
    issue16(4'b1000, 3'd0, 3'd0, 3'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, cyc);
    s_dbg_addr = 3'd2; #1;
    n_vec++; if (s_dbg_data !== 16'h0003) begin n_bad++; $display("[TB] FAIL mdata_r2 got %h want 0003", s_dbg_data); end
  endtask

  task automatic test_add_shift;
    int cyc;
    issue16(4'b0001, 3'd1, 3'd2, 3'd3, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, cyc);
    n_vec++; if (cyc != 5) begin n_bad++; $display("[TB] FAIL add_latency got %0d want 5", cyc); end
    n_vec++; if (s_out !== 16'h000D) begin n_bad++; $display("[TB] FAIL add_out got %h want 000D", s_out); end
    n_vec++; if (s_status !== 3'b000) begin n_bad++; $display("[TB] FAIL add_status got %b want 000", s_status); end
    s_dbg_addr = 3'd3; #1;
    n_vec++; if (s_dbg_data !== 16'h000D) begin n_bad++; $display("[TB] FAIL add_r3 got %h want 000D", s_dbg_data); end
  endtask

  task automatic test_overflow;
    int cyc;
    s_imm8 = 16'h7FFF;
    issue16(4'b0100, 3'd0, 3'd0, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, cyc);
    s_imm8 = 16'h0001;
    issue16(4'b0100, 3'd0, 3'd0, 3'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, cyc);
    issue16(4'b0001, 3'd1, 3'd2, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, cyc);
    n_vec++; if (s_out !== 16'h8000) begin n_bad++; $display("[TB] FAIL ovf_out got %h want 8000", s_out); end
    n_vec++; if (s_status !== 3'b110) begin n_bad++; $display("[TB] FAIL ovf_status got %b want 110", s_status); end
    s_dbg_addr = 3'd3; #1;
    n_vec++; if (s_dbg_data !== 16'h000D) begin n_bad++; $display("[TB] FAIL cmp_r3_kept got %h want 000D", s_dbg_data); end
  endtask

  task automatic test_sub_zero;
    int cyc;
    issue16(4'b0001, 3'd1, 3'd1, 3'd5, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, cyc);
    n_vec++; if (s_out !== 16'h0000) begin n_bad++; $display("[TB] FAIL sub_out got %h want 0000", s_out); end
    n_vec++; if (s_status !== 3'b001) begin n_bad++; $display("[TB] FAIL sub_status got %b want 001", s_status); end
  endtask

  task automatic test_back_to_back;
    int ndone;
    ndone = 0;
    s_vsel = 4'b0001; s_rn = 3'd1; s_rm = 3'd2; s_rd = 3'd6; s_aluop = 2'b00; s_shift = 2'b00;
    s_asel = 1'b0; s_bsel = 1'b0; s_wb = 1'b0; s_start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 10) s_start = 1'b0;
      if (s_done) ndone++;
      n_vec++;
      if (s_done !== ((c == 5) || (c == 10))) begin
        n_bad++; $display("[TB] FAIL hold_done_c%0d got %b want %b", c, s_done, (c == 5) || (c == 10));
      end
    end
    n_vec++; if (ndone != 2) begin n_bad++; $display("[TB] FAIL hold_count got %0d want 2", ndone); end
    n_vec++; if (s_status !== 3'b110) begin n_bad++; $display("[TB] FAIL hold_status got %b want 110", s_status); end
  endtask

  task automatic test_illegal;
    int cyc;
    s_mdata = 16'hBEEF;
    issue16(4'b0011, 3'd0, 3'd0, 3'd4, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, cyc);
    n_vec++; if (cyc != 2) begin n_bad++; $display("[TB] FAIL illegal_latency got %0d want 2", cyc); end
    n_vec++; if (s_err !== 1'b1) begin n_bad++; $display("[TB] FAIL illegal_err got %b want 1", s_err); end
    s_dbg_addr = 3'd4; #1;
    n_vec++; if (s_dbg_data !== 16'h0000) begin n_bad++; $display("[TB] FAIL illegal_r4 got %h want 0000", s_dbg_data); end
    @(negedge clk);
    n_vec++; if (s_err !== 1'b0 || s_done !== 1'b0) begin
      n_bad++; $display("[TB] FAIL illegal_pulse got err=%b done=%b want 0/0", s_err, s_done);
    end
  endtask

  task automatic test_abort;
    s_vsel = 4'b0001; s_rn = 3'd1; s_rm = 3'd1; s_rd = 3'd6; s_aluop = 2'b00; s_shift = 2'b00;
    s_asel = 1'b0; s_bsel = 1'b0; s_wb = 1'b1; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0; #1;
    n_vec++; if (s_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_busy got %b want 0", s_busy); end
    n_vec++; if (s_status !== 3'b000) begin n_bad++; $display("[TB] FAIL abort_status got %b want 000", s_status); end
    n_vec++; if (s_out !== 16'h0000) begin n_bad++; $display("[TB] FAIL abort_out got %h want 0000", s_out); end
    for (int i = 0; i < 8; i++) begin
      s_dbg_addr = 3'(i); #1;
      n_vec++; if (s_dbg_data !== 16'h0000) begin n_bad++; $display("[TB] FAIL abort_reg%0d got %h want 0000", i, s_dbg_data); end
    end
    @(negedge clk);
    n_vec++; if (s_done !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_done got %b want 0", s_done); end
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
    mc = 8'h00; mstat = 3'b000;
  endtask

  // Applies one command to the 8-bit instance and to the model, then compares.
  task automatic run8_cmd(input logic [3:0] vsel, input logic [1:0] rn, input logic [1:0] rm,
                          input logic [1:0] rd, input logic [1:0] aluop, input logic [1:0] shift,
                          input logic asel, input logic bsel, input logic wb,
                          input logic [7:0] imm8, input logic [7:0] imm5,
                          input logic [7:0] md, input logic [7:0] pc);
    logic [7:0] a, b, res;
    int sa, sb, full, exp_cyc, cyc;
    logic v, exp_err;
    exp_err = 1'b0; exp_cyc = 2;
    if (vsel == 4'b0001) begin
      a = asel ? 8'h00 : mrf[rn];
      b = mrf[rm];
      if (shift == 2'b01) b = b << 1;
      else if (shift == 2'b10) b = b >> 1;
      else if (shift == 2'b11) b = 8'($signed(b) >>> 1);
      if (bsel) b = imm5;
      sa = int'($signed(a)); sb = int'($signed(b)); v = 1'b0;
      case (aluop)
        2'b00: begin full = sa + sb; res = 8'(full); v = (full > 127) || (full < -128); end
        2'b01: begin full = sa - sb; res = 8'(full); v = (full > 127) || (full < -128); end
        2'b10: res = a & b;
        default: res = ~b;
      endcase
      mc = res; mstat = {res[7], v, res == 8'h00};
      if (wb) mrf[rd] = res;
      exp_cyc = 5;
    end else if (vsel == 4'b1000) begin if (wb) mrf[rd] = md; end
    else if (vsel == 4'b0100) begin if (wb) mrf[rd] = imm8; end
    else if (vsel == 4'b0010) begin if (wb) mrf[rd] = pc; end
    else exp_err = 1'b1;

    e_vsel = vsel; e_rn = rn; e_rm = rm; e_rd = rd; e_aluop = aluop; e_shift = shift;
    e_asel = asel; e_bsel = bsel; e_wb = wb; e_imm8 = imm8; e_imm5 = imm5; e_mdata = md; e_pc = pc;
    e_start = 1'b1; cyc = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      e_start = 1'b0;
      if (e_done) begin cyc = i; break; end
    end
    n_vec++; if (cyc != exp_cyc) begin n_bad++; $display("[TB] FAIL rnd_latency vsel=%b got %0d want %0d", vsel, cyc, exp_cyc); end
    n_vec++; if (e_err !== exp_err) begin n_bad++; $display("[TB] FAIL rnd_err vsel=%b got %b want %b", vsel, e_err, exp_err); end
    n_vec++; if (e_out !== mc) begin n_bad++; $display("[TB] FAIL rnd_out got %h want %h", e_out, mc); end
    n_vec++; if (e_status !== mstat) begin n_bad++; $display("[TB] FAIL rnd_status got %b want %b", e_status, mstat); end
    e_dbg_addr = rd; #1;
    n_vec++; if (e_dbg_data !== mrf[rd]) begin n_bad++; $display("[TB] FAIL rnd_reg%0d got %h want %h", rd, e_dbg_data, mrf[rd]); end
  endtask

  task automatic test_asr_not8;
    run8_cmd(4'b1000, 2'd0, 2'd0, 2'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h80, 8'h00);
    run8_cmd(4'b0001, 2'd0, 2'd0, 2'd1, 2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    n_vec++; if (e_out !== 8'h3F) begin n_bad++; $display("[TB] FAIL asr_not_out got %h want 3F", e_out); end
    n_vec++; if (e_status[2] !== 1'b0) begin n_bad++; $display("[TB] FAIL asr_not_n got %b want 0", e_status[2]); end
  endtask

  task automatic test_random8;
    logic [3:0] vsel;
    int pick;
    for (int k = 0; k < 1000; k++) begin
      pick = int'($urandom_range(0, 7));
      case (pick)
        0: vsel = 4'b1000;
        1: vsel = 4'b0100;
        2: vsel = 4'b0010;
        7: begin
          vsel = 4'($urandom_range(0, 15));
          if ($countones(vsel) == 1) vsel = 4'b0000;
        end
        default: vsel = 4'b0001;
      endcase
      run8_cmd(vsel, 2'($urandom()), 2'($urandom()), 2'($urandom()), 2'($urandom()), 2'($urandom()),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0),
               8'($urandom()), 8'($urandom()), 8'($urandom()), 8'($urandom()));
      if (k % 100 == 99) begin
        for (int i = 0; i < 4; i++) begin
          e_dbg_addr = 2'(i); #1;
          n_vec++; if (e_dbg_data !== mrf[i]) begin n_bad++; $display("[TB] FAIL scan_reg%0d got %h want %h", i, e_dbg_data, mrf[i]); end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset;
    test_direct;
    test_add_shift;
    test_overflow;
    test_sub_zero;
    test_back_to_back;
    test_illegal;
    test_abort;
    test_asr_not8;
    test_random8;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
